// File: rtl/mvm_shift_add.sv
// mvm_shift_add
// Bit-serial shift-and-add accumulator behind the MVM crossbar. One crossbar
// output vector arrives per input bit-slice, LSB slice first. Slice k is
// weighted by 2^k and added into a per-lane accumulator. After the last
// slice, the full-precision vector is held on a valid/ready output.
//
// Build option: define MVM_SNA_SATURATE_EN to clamp each lane at
// 2^ACC_BITS-1 and to raise a sticky per-frame sat_flag. Without the macro,
// lanes wrap modulo 2^ACC_BITS and sat_flag is tied low.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous flush back to IDLE (highest priority)
//   in_valid   slice vector present (MVM done pulse)
//   in_data    XBAR_SIZE lanes x OUT_BITS, lane i at [i*OUT_BITS +: OUT_BITS]
//   in_ready   a slice can be accepted this cycle
//   out_valid  result vector valid
//   out_ready  consumer accepts the result
//   out_data   XBAR_SIZE lanes x ACC_BITS, registered straight from acc
//   busy       frame in progress (ACCUM or HOLD)
//   slice_idx  index of the next slice expected
//   sat_flag   some lane clamped during this frame (saturating build only)
//
// state  | meaning
// IDLE   | no frame open, accumulators zero, waiting for slice 0
// ACCUM  | slices 1..NUM_SLICES-1 being accumulated
// HOLD   | result presented, waiting for out_ready

module mvm_shift_add #(
    parameter int XBAR_SIZE  = 128,
    parameter int OUT_BITS   = 16,
    parameter int NUM_SLICES = 16,
    parameter int ACC_BITS   = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clear,
    input  logic                                          in_valid,
    input  logic [OUT_BITS*XBAR_SIZE-1:0]                 in_data,
    output logic                                          in_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [ACC_BITS*XBAR_SIZE-1:0]                 out_data,
    output logic                                          busy,
    output logic [(NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1)-1:0] slice_idx,
    output logic                                          sat_flag
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 flush;
    logic                 last_slice;
    logic [ACC_BITS-1:0]  acc     [XBAR_SIZE];
    logic [ACC_BITS-1:0]  acc_nxt [XBAR_SIZE];

    assign last_slice = (slice_idx == IDX_W'(NUM_SLICES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        flush     = 1'b0;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = last_slice ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (clear) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = last_slice ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                busy      = 1'b1;
                in_ready  = 1'b0;
                out_valid = 1'b1;
                // in_valid here is a protocol error; the slice is dropped
                if (clear || out_ready) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                flush     = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // In IDLE acc is zero and slice_idx is zero, so the same add covers the
    // "load slice 0" case without a separate path.
`ifdef MVM_SNA_SATURATE_EN
    localparam int SUM_W = ACC_BITS + OUT_BITS + NUM_SLICES;
    logic [SUM_W-1:0] lane_sum [XBAR_SIZE];
    logic             any_sat;

    // Full-width sum keeps bits shifted past ACC_BITS so they count as overflow.
    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < XBAR_SIZE; i++) begin
            lane_sum[i] = SUM_W'(acc[i])
                        + (SUM_W'(in_data[i*OUT_BITS +: OUT_BITS]) << slice_idx);
            if (|lane_sum[i][SUM_W-1:ACC_BITS]) begin
                acc_nxt[i] = '1;
                any_sat    = 1'b1;
            end else begin
                acc_nxt[i] = lane_sum[i][ACC_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else if (flush) begin
            sat_flag <= 1'b0;
        end else if (accept && any_sat) begin
            sat_flag <= 1'b1;
        end
    end
`else
    // Shift inside ACC_BITS so bits above the lane width fall off before the add.
    always_comb begin
        for (int i = 0; i < XBAR_SIZE; i++) begin
            acc_nxt[i] = acc[i] + (ACC_BITS'(in_data[i*OUT_BITS +: OUT_BITS]) << slice_idx);
        end
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slice_idx <= '0;
            for (int i = 0; i < XBAR_SIZE; i++) begin
                acc[i] <= '0;
            end
        end else if (flush) begin
            slice_idx <= '0;
            for (int i = 0; i < XBAR_SIZE; i++) begin
                acc[i] <= '0;
            end
        end else if (accept) begin
            slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
            for (int i = 0; i < XBAR_SIZE; i++) begin
                acc[i] <= acc_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < XBAR_SIZE; g++) begin : g_out
        assign out_data[g*ACC_BITS +: ACC_BITS] = acc[g];
    end

endmodule

// File: tb/tb_mvm_shift_add.sv
// Self-checking bench for mvm_shift_add. A reference model computes each
// lane as the plain sum of slice*2^k, then wraps or clamps it. Expected
// frames go into a queue that a negedge monitor drains on each output
// handshake. A second, narrow instance (ACC_BITS=20) covers overflow.

module tb_mvm_shift_add;

    localparam int X     = 128;
    localparam int OB    = 16;
    localparam int NS    = 16;
    localparam int AB    = 32;
    localparam int IN_W  = X * OB;
    localparam int OUT_W = X * AB;
    localparam int X2    = 4;
    localparam int AB2   = 20;

`ifdef MVM_SNA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic [3:0]       slice_idx;
    logic             sat_flag;

    logic               in_valid20;
    logic [X2*OB-1:0]   in_data20;
    logic               in_ready20;
    logic               out_valid20;
    logic               out_ready20;
    logic [X2*AB2-1:0]  out_data20;
    logic               busy20;
    logic [3:0]         slice_idx20;
    logic               sat_flag20;

    always #5 clk = ~clk;

    mvm_shift_add #(.XBAR_SIZE(X), .OUT_BITS(OB), .NUM_SLICES(NS), .ACC_BITS(AB)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .slice_idx(slice_idx), .sat_flag(sat_flag)
    );

    mvm_shift_add #(.XBAR_SIZE(X2), .OUT_BITS(OB), .NUM_SLICES(NS), .ACC_BITS(AB2)) dut20 (
        .clk(clk), .reset(reset), .clear(1'b0),
        .in_valid(in_valid20), .in_data(in_data20), .in_ready(in_ready20),
        .out_valid(out_valid20), .out_ready(out_ready20), .out_data(out_data20),
        .busy(busy20), .slice_idx(slice_idx20), .sat_flag(sat_flag20)
    );

    int               n_vec  = 0;
    int               n_miss = 0;
    logic [OUT_W-1:0] exp_q [$];
    logic [IN_W-1:0]  frame_sl [NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_out(input string name);
        n_vec++;
        if (out_data !== '0) begin
            n_miss++;
            $display("FAIL %s: out_data not zero, lane0 got %0h at %0t", name, out_data[AB-1:0], $time);
        end
    endtask

    // Lane result = sum over k of slice_k * 2^k, then clamp or wrap to AB bits.
    function automatic logic [OUT_W-1:0] model_frame();
        logic [OUT_W-1:0] r;
        logic [63:0]      tot;
        logic [63:0]      lim;
        r   = '0;
        lim = (64'd1 << AB) - 64'd1;
        for (int i = 0; i < X; i++) begin
            tot = 64'd0;
            for (int k = 0; k < NS; k++) begin
                tot = tot + (64'(frame_sl[k][i*OB +: OB]) << k);
            end
            if (SAT && tot > lim) tot = lim;
            r[i*AB +: AB] = tot[AB-1:0];
        end
        return r;
    endfunction

    task automatic gen(input int mode);
        for (int k = 0; k < NS; k++) begin
            for (int i = 0; i < X; i++) begin
                case (mode)
                    0:       frame_sl[k][i*OB +: OB] = 16'd1;
                    1:       frame_sl[k][i*OB +: OB] = (i == 0) ? 16'hFFFF :
                                                       (i == 1) ? 16'h0000 : 16'($urandom);
                    2:       frame_sl[k][i*OB +: OB] = 16'd2;
                    default: frame_sl[k][i*OB +: OB] = 16'($urandom);
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full frame: optional idle gaps between slices, hold cycles in HOLD with
    // out_ready low, and optional illegal in_valid pokes while held.
    task automatic run_frame(input int mode, input int gap_max, input int hold, input bit poke);
        logic [OUT_W-1:0] e;
        gen(mode);
        e = model_frame();
        exp_q.push_back(e);
        out_ready = 1'b0;
        for (int k = 0; k < NS; k++) begin
            repeat ($urandom_range(gap_max, 0)) tick();
            check("in_ready_before_slice", 64'(in_ready), 64'd1);
            send(frame_sl[k]);
            check("slice_idx", 64'(slice_idx), 64'((k + 1) % NS));
            check("busy", 64'(busy), 64'd1);
            check("out_valid_latency", 64'(out_valid), (k == NS - 1) ? 64'd1 : 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_data  = {X{16'($urandom)}};
                in_valid = 1'b1;
            end
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            n_vec++;
            if (out_data !== e) begin
                n_miss++;
                $display("FAIL hold_stable: lane0 got %0h expected %0h", out_data[AB-1:0], e[AB-1:0]);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_busy", 64'(busy), 64'd0);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_slice_idx", 64'(slice_idx), 64'd0);
        check_zero_out("post_hs_acc_cleared");
    endtask

    logic [OUT_W-1:0] mon_e;
    int               mon_bad;

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output: got lane0 %0h expected no result", out_data[AB-1:0]);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_bad = -1;
                for (int i = 0; i < X; i++) begin
                    if (mon_bad < 0 && out_data[i*AB +: AB] !== mon_e[i*AB +: AB]) mon_bad = i;
                end
                if (mon_bad >= 0) begin
                    n_miss++;
                    $display("FAIL frame_result: lane %0d got %0h expected %0h", mon_bad,
                             out_data[mon_bad*AB +: AB], mon_e[mon_bad*AB +: AB]);
                end
                check("frame_sat_flag", 64'(sat_flag), 64'd0);
            end
        end
    end

    initial begin
        reset       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        in_valid20  = 1'b0;
        in_data20   = '0;
        out_ready20 = 1'b0;

        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_slice_idx", 64'(slice_idx), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check_zero_out("rst_out_data");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // all lanes 1, back-to-back slices -> 0xFFFF per lane
        run_frame(0, 0, 0, 1'b0);
        // lane0 0xFFFF, lane1 0 -> 0xFFFE0001 / 0; held 10 cycles with illegal pokes
        run_frame(1, 1, 10, 1'b1);

        // clear with in_valid after 7 slices
        gen(3);
        for (int k = 0; k < 7; k++) send(frame_sl[k]);
        check("pre_clear_slice_idx", 64'(slice_idx), 64'd7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = {X{16'($urandom)}};
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_slice_idx", 64'(slice_idx), 64'd0);
        check("clear_out_valid", 64'(out_valid), 64'd0);
        check("clear_in_ready", 64'(in_ready), 64'd1);
        check_zero_out("clear_acc");
        // all 2s -> 0x1FFFE per lane
        run_frame(2, 0, 1, 1'b0);

        for (int f = 0; f < 4; f++) run_frame(3, 3, $urandom_range(3, 0), 1'($urandom_range(1, 0)));

        // async reset mid-frame, after slice 5
        gen(3);
        for (int k = 0; k < 5; k++) send(frame_sl[k]);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_slice_idx", 64'(slice_idx), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check_zero_out("async_rst_acc");
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_frame(3, 2, 2, 1'b0);

        // narrow accumulator: 0xFFFF on every slice overflows 20 bits
        for (int k = 0; k < NS; k++) begin
            in_data20  = {X2{16'hFFFF}};
            in_valid20 = 1'b1;
            tick();
            in_valid20 = 1'b0;
        end
        check("acc20_out_valid", 64'(out_valid20), 64'd1);
        for (int i = 0; i < X2; i++) begin
            check("acc20_lane", 64'(out_data20[i*AB2 +: AB2]), SAT ? 64'hFFFFF : 64'hE0001);
        end
        check("acc20_sat_flag", 64'(sat_flag20), 64'(SAT));
        out_ready20 = 1'b1;
        tick();
        out_ready20 = 1'b0;
        check("acc20_sat_cleared", 64'(sat_flag20), 64'd0);
        check("acc20_idle", 64'(busy20), 64'd0);

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
